// File: rtl/aes128_inv_pkg.sv
// Shared types, tables and byte/state helpers for the iterative AES-128
// inverse cipher. A state_t is 4 columns x 4 rows of bytes, column-major:
// element [c][r] is byte 4*c+r of the big-endian 128-bit block, so a plain
// 128-bit vector can be assigned to a state_t without reordering.
package aes128_inv_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int CNT_W      = $clog2(NUM_ROUNDS);

    typedef logic [7:0]              byte_t;
    typedef logic [31:0]             word_t;
    typedef logic [0:3][0:3][7:0]    state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_DEC    = 2'd2,
        ST_FINAL  = 2'd3
    } fsm_t;

    localparam byte_t SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    localparam byte_t RCON [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ ({8{b[7]}} & 8'h1b);
    endfunction

    // Only the InvMixColumns coefficients are needed.
    function automatic byte_t gmul(input byte_t b, input byte_t c);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h09:   return x8 ^ b;
            8'h0b:   return x8 ^ x2 ^ b;
            8'h0d:   return x8 ^ x4 ^ b;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return b;
        endcase
    endfunction

    // Row r is rotated right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[2'(c)][2'(r)] = s[2'(c - r)][2'(r)];
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[2'(c)][2'(r)] = INV_SBOX[s[2'(c)][2'(r)]];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            byte_t a0, a1, a2, a3;
            a0 = s[2'(c)][0];
            a1 = s[2'(c)][1];
            a2 = s[2'(c)][2];
            a3 = s[2'(c)][3];
            o[2'(c)][0] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[2'(c)][1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[2'(c)][2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[2'(c)][3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_inv_keysched.sv
// Combinational AES-128 key-schedule step, both directions.
//   key     : current 128-bit round key
//   rcon    : round constant for the step
//   fwd_key : next round key  K(i) -> K(i+1)
//   inv_key : previous round key K(i) -> K(i-1)
// The reverse step first rebuilds word 3 of K(i-1) from K(i), so it also
// only needs the forward S-box.
module aes128_inv_keysched
    import aes128_inv_pkg::*;
(
    input  logic [127:0] key,
    input  byte_t        rcon,
    output logic [127:0] fwd_key,
    output logic [127:0] inv_key
);

    function automatic word_t sub_rot(input word_t w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    word_t k0, k1, k2, k3;
    word_t f0, f1, f2, f3;
    word_t p0, p1, p2, p3;

    assign {k0, k1, k2, k3} = key;

    assign f0 = k0 ^ sub_rot(k3) ^ {rcon, 24'h0};
    assign f1 = k1 ^ f0;
    assign f2 = k2 ^ f1;
    assign f3 = k3 ^ f2;

    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign p0 = k0 ^ sub_rot(p3) ^ {rcon, 24'h0};

    assign fwd_key = {f0, f1, f2, f3};
    assign inv_key = {p0, p1, p2, p3};

endmodule

// File: rtl/aes128_inv.sv
// Iterative AES-128 decryption core, one round per clock.
//   Clk_CI, Reset_RI          : clock, synchronous active-high reset
//   Start_SI, NewCipherkey_SI : start request (taken only when idle) and
//                               "expand Cipherkey_DI first" qualifier
//   Ciphertext_DI, Cipherkey_DI : block and key sampled on accepted start
//   Busy_SO, Valid_SO         : busy flag, one-cycle result strobe
//   Plaintext_DO              : registered result, held until next strobe
// The expanded last round key (K10) is kept so later blocks under the same
// key skip the 10-cycle expansion and walk the schedule backwards instead.
module aes128_inv
    import aes128_inv_pkg::*;
(
    input  logic         Clk_CI,
    input  logic         Reset_RI,
    input  logic         Start_SI,
    input  logic         NewCipherkey_SI,
    output logic         Busy_SO,
    output logic         Valid_SO,
    input  logic [127:0] Ciphertext_DI,
    input  logic [127:0] Cipherkey_DI,
    output logic [127:0] Plaintext_DO
);

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q;
    logic [127:0]     state_q, key_q, last_key_q, pt_q;
    logic             key_valid_q, vld_q;

    logic             cnt_last, need_exp;
    logic [CNT_W-1:0] rcon_idx;
    logic [127:0]     fwd_key, inv_key, ark, round_in, round_out;

    assign cnt_last = (cnt_q == CNT_W'(NUM_ROUNDS - 1));
    assign need_exp = NewCipherkey_SI || !key_valid_q;

    // Expansion counts rcon up; decryption walks it back down.
    assign rcon_idx = (fsm_q == ST_DEC) ? CNT_W'(NUM_ROUNDS - 1) - cnt_q : cnt_q;

    aes128_inv_keysched u_keysched (
        .key     (key_q),
        .rcon    (RCON[rcon_idx]),
        .fwd_key (fwd_key),
        .inv_key (inv_key)
    );

    // The first round (cnt 0) adds K10 without InvMixColumns.
    assign ark       = state_q ^ key_q;
    assign round_in  = (cnt_q == '0) ? ark : inv_mix_columns(ark);
    assign round_out = inv_sub_bytes(inv_shift_rows(round_in));

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) fsm_q <= ST_IDLE;
        else          fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:   if (Start_SI) fsm_d = need_exp ? ST_KEYEXP : ST_DEC;
            ST_KEYEXP: if (cnt_last) fsm_d = ST_DEC;
            ST_DEC:    if (cnt_last) fsm_d = ST_FINAL;
            ST_FINAL:  fsm_d = ST_IDLE;
            default:   fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy_SO      = (fsm_q != ST_IDLE);
        Valid_SO     = vld_q;
        Plaintext_DO = pt_q;
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            cnt_q       <= '0;
            state_q     <= '0;
            key_q       <= '0;
            last_key_q  <= '0;
            pt_q        <= '0;
            key_valid_q <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (Start_SI) begin
                        state_q <= Ciphertext_DI;
                        key_q   <= need_exp ? Cipherkey_DI : last_key_q;
                        cnt_q   <= '0;
                    end
                end
                ST_KEYEXP: begin
                    key_q <= fwd_key;
                    if (cnt_last) begin
                        last_key_q  <= fwd_key;
                        key_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DEC: begin
                    state_q <= round_out;
                    key_q   <= inv_key;
                    cnt_q   <= cnt_last ? '0 : cnt_q + 1'b1;
                end
                ST_FINAL: begin
                    pt_q  <= ark;
                    vld_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_inv.sv
// Self-checking bench for aes128_inv: a textbook AES-128 model (S-box
// derived from GF(2^8) inversion plus the affine map, full key expansion,
// forward and inverse cipher) predicts busy/valid/plaintext every cycle,
// and directed FIPS-197 vectors pin both the model and the core.
module tb_aes128_inv;

    logic         Clk_CI = 1'b0;
    logic         Reset_RI, Start_SI, NewCipherkey_SI;
    logic         Busy_SO, Valid_SO;
    logic [127:0] Ciphertext_DI, Cipherkey_DI, Plaintext_DO;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];

    localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes128_inv dut (
        .Clk_CI          (Clk_CI),
        .Reset_RI        (Reset_RI),
        .Start_SI        (Start_SI),
        .NewCipherkey_SI (NewCipherkey_SI),
        .Busy_SO         (Busy_SO),
        .Valid_SO        (Valid_SO),
        .Ciphertext_DI   (Ciphertext_DI),
        .Cipherkey_DI    (Cipherkey_DI),
        .Plaintext_DO    (Plaintext_DO)
    );

    initial forever #5 Clk_CI = ~Clk_CI;

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] r, bx;
            bx = 8'(x);
            r  = 8'h01;
            for (int k = 0; k < 254; k++) r = gfmul(r, bx);
            sbox_m[x] = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_m[sbox_m[x]] = 8'(x);
    endtask

    function automatic logic [7:0] gb(input logic [127:0] x, input int i);
        return x[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv ? isbox_m[gb(x, i)] : sbox_m[gb(x, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                int src;
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127 - 8*(4*c + r) -: 8] = gb(x, 4*src + r);
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] x, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc;
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gfmul(gb(x, 4*c + j), m[(j - r + 4) % 4]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int rnd);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gfmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        s = pt ^ round_key(k, 0);
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 0), 0);
            if (r < 10) s = mix_cols(s, 0);
            s = s ^ round_key(k, r);
        end
        return s;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [127:0] s;
        s = ct ^ round_key(k, 10);
        for (int r = 9; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1), 1) ^ round_key(k, r);
            if (r > 0) s = mix_cols(s, 1);
        end
        return s;
    endfunction

    // Cycle-level prediction of the visible interface, checked every cycle.
    initial begin : model_cmp
        int           rem;
        bit           kv, mvld, seen_rst;
        logic [127:0] mkey, pend, mpt;
        rem = 0; kv = 0; mvld = 0; seen_rst = 0;
        mkey = '0; pend = '0; mpt = '0;
        forever begin
            @(posedge Clk_CI);
            if (Reset_RI) begin
                rem = 0; kv = 0; mvld = 0; mpt = '0; seen_rst = 1;
            end else begin
                mvld = 0;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin mvld = 1; mpt = pend; end
                end else if (Start_SI) begin
                    if (NewCipherkey_SI || !kv) begin
                        mkey = Cipherkey_DI; kv = 1; rem = 21;
                    end else begin
                        rem = 11;
                    end
                    pend = decrypt(Ciphertext_DI, mkey);
                end
            end
            @(negedge Clk_CI);
            if (seen_rst) begin
                chk("cyc_busy",  128'(Busy_SO),  128'(rem > 0));
                chk("cyc_valid", 128'(Valid_SO), 128'(mvld));
                chk("cyc_pt",    Plaintext_DO,   mpt);
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy_SO && n < 50) begin @(negedge Clk_CI); n++; end
        if (Busy_SO) chk("idle_timeout", 128'(Busy_SO), 128'd0);
    endtask

    task automatic issue(input logic [127:0] ct, input logic [127:0] key, input bit nk);
        Ciphertext_DI   = ct;
        Cipherkey_DI    = key;
        NewCipherkey_SI = nk;
        Start_SI        = 1'b1;
        @(negedge Clk_CI);
        Start_SI        = 1'b0;
        NewCipherkey_SI = 1'b0;
    endtask

    // lat counts edges from the accepting edge to the edge raising Valid_SO.
    task automatic wait_valid(input bit garbage, output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!Valid_SO && lat < 40) begin
            if (Busy_SO) bcnt++;
            if (garbage && (lat == 3 || lat == 7)) begin
                Start_SI = 1'b1; NewCipherkey_SI = 1'b1;
                Ciphertext_DI = rnd128(); Cipherkey_DI = rnd128();
            end else begin
                Start_SI = 1'b0; NewCipherkey_SI = 1'b0;
            end
            @(negedge Clk_CI);
            lat++;
        end
        Start_SI = 1'b0; NewCipherkey_SI = 1'b0;
        if (!Valid_SO) chk("valid_timeout", 128'(Valid_SO), 128'd1);
    endtask

    task automatic run_op(input logic [127:0] ct, input logic [127:0] key, input bit nk,
                          input bit garbage, output int lat, output int bcnt);
        wait_idle();
        issue(ct, key, nk);
        wait_valid(garbage, lat, bcnt);
    endtask

    initial begin : main
        int           lat, bcnt, vcount;
        logic [127:0] cur_key, k, pt, ct;
        bit           nk;
        Reset_RI = 1'b1; Start_SI = 1'b0; NewCipherkey_SI = 1'b0;
        Ciphertext_DI = '0; Cipherkey_DI = '0;
        build_sbox();

        chk("model_sbox_53",  128'(sbox_m[8'h53]), 128'h00ed);
        chk("model_k10_c1",   round_key(K_C1, 10), K10_C1);
        chk("model_k10_b",    round_key(K_B, 10),  K10_B);
        chk("model_enc_c1",   encrypt(PT_C1, K_C1), CT_C1);
        chk("model_dec_b",    decrypt(CT_B, K_B),   PT_B);

        repeat (3) @(negedge Clk_CI);
        Reset_RI = 1'b0;
        chk("rst_busy",  128'(Busy_SO),  128'd0);
        chk("rst_valid", 128'(Valid_SO), 128'd0);
        chk("rst_pt",    Plaintext_DO,   128'd0);

        run_op(CT_C1, K_C1, 1'b1, 1'b0, lat, bcnt);
        chk("c1_lat", 128'(lat), 128'd21);
        chk("c1_pt",  Plaintext_DO, PT_C1);
        chk("c1_k10", dut.last_key_q, K10_C1);

        run_op(CT_C1, K_B, 1'b0, 1'b0, lat, bcnt);
        chk("stored_lat",  128'(lat),  128'd11);
        chk("stored_busy", 128'(bcnt), 128'd11);
        chk("stored_pt",   Plaintext_DO, PT_C1);

        run_op(CT_B, K_B, 1'b1, 1'b0, lat, bcnt);
        chk("b_lat", 128'(lat), 128'd21);
        chk("b_pt",  Plaintext_DO, PT_B);
        chk("b_k10", dut.last_key_q, K10_B);

        run_op(CT_B, K_C1, 1'b0, 1'b1, lat, bcnt);
        chk("ignore_lat", 128'(lat), 128'd11);
        chk("ignore_pt",  Plaintext_DO, PT_B);

        // Start on the Valid_SO cycle is accepted straight away.
        issue(CT_B, K_C1, 1'b0);
        wait_valid(1'b0, lat, bcnt);
        chk("b2b_spacing", 128'(lat + 1), 128'd12);
        chk("b2b_pt",      Plaintext_DO, PT_B);

        // Reset lands on the edge that would execute DEC round cnt=5.
        wait_idle();
        issue(CT_B, K_C1, 1'b0);
        repeat (5) @(negedge Clk_CI);
        Reset_RI = 1'b1;
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        chk("midrst_busy",  128'(Busy_SO),  128'd0);
        chk("midrst_pt",    Plaintext_DO,   128'd0);
        chk("midrst_valid", 128'(Valid_SO), 128'd0);
        chk("midrst_kv",    128'(dut.key_valid_q), 128'd0);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk_CI);
            if (Valid_SO) vcount++;
        end
        chk("midrst_novalid", 128'(vcount), 128'd0);
        run_op(CT_B, K_B, 1'b0, 1'b0, lat, bcnt);
        chk("postrst_lat", 128'(lat), 128'd21);
        chk("postrst_pt",  Plaintext_DO, PT_B);
        cur_key = K_B;

        for (int v = 0; v < 1000; v++) begin
            nk = ($urandom_range(0, 2) == 0);
            if (nk) cur_key = rnd128();
            pt = rnd128();
            ct = encrypt(pt, cur_key);
            k  = nk ? cur_key : rnd128();
            run_op(ct, k, nk, 1'b0, lat, bcnt);
            chk("xchk_pt",  Plaintext_DO, pt);
            chk("xchk_lat", 128'(lat), nk ? 128'd21 : 128'd11);
        end

        repeat (2) @(negedge Clk_CI);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
